// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmitter. It sits between the bus register logic and the TX pin,
//   and it is the partner of the UART-RX receive path. Each accepted request
//   sends one 11-bit frame: start(0), D0..D7 (LSB first), parity slot, stop(1).
//   A built-in baud counter makes every bit exactly BPS_CNT clock cycles long.
//
// Ports
//   CLK          in   system clock, rising edge
//   RSTn         in   asynchronous, active-low reset
//   TX_En_Sig    in   1 = run, 0 = freeze the frame in flight (no accepts)
//   TX_Start     in   request, sampled only in IDLE with TX_En_Sig=1
//   TX_Data[7:0] in   byte to send, captured on the accepting cycle
//   TX_Busy      out  high from accept until the frame has completed
//   TX_Done_Sig  out  one-cycle pulse after the stop bit has finished
//   TX_Pin_Out   out  serial line, idle high
//
// Configuration
//   UART_TX_PARITY_EN  defined  : parity slot carries the parity of TX_Data
//                                  (even, or odd when PARITY_ODD=1)
//                      undefined: parity slot is a mark (1) and no parity
//                                  logic is built; frame length is unchanged
//
// Handshake: a request is taken on a rising edge where state is IDLE,
//   TX_En_Sig=1 and TX_Start=1. TX_Busy rises on that edge. Requests that
//   arrive while the block is busy or in the DONE cycle are dropped, not
//   queued. The next request can be accepted on the edge after the
//   TX_Done_Sig pulse begins.
//
// The current FSM state is held in the 'state' signal, typed tx_state_t.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic       TX_Start,
  input  logic [7:0] TX_Data,
  output logic       TX_Busy,
  output logic       TX_Done_Sig,
  output logic       TX_Pin_Out
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } tx_state_t;

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       shreg;
  logic             par_q;
  logic             accept;
  logic             bit_end;
  logic             pin_next;

  assign bit_end = (cnt == CNT_MAX);

  // Parity slot
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= PARITY_ODD ? ~^TX_Data : ^TX_Data;
    end
  end
`else
  // PARITY_ODD has no meaning without parity; OR-ing it in keeps the slot
  // a constant mark.
  assign par_q = 1'b1 | PARITY_ODD;
`endif

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, baud counter and bit index. With TX_En_Sig low nothing moves,
  // so a frozen frame resumes on exactly the cycle it stopped at.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    accept     = 1'b0;
    if (TX_En_Sig) begin
      if (state != IDLE) begin
        cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (TX_Start) begin
            accept     = 1'b1;
            state_next = START;
            cnt_next   = '0;
          end
        end
        START: begin
          if (bit_end) state_next = DATA;
        end
        DATA: begin
          if (bit_end) begin
            if (idx == 3'd7) begin
              idx_next   = 3'd0;
              state_next = PARITY;
            end else begin
              idx_next = idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) state_next = STOP;
        end
        STOP: begin
          if (bit_end) state_next = DONE;
        end
        DONE: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = 3'd0;
        end
      endcase
    end
  end

  // Line level for the current state; registered below, so the pin trails the
  // state by one cycle (the start bit appears on the edge after the accept).
  always_comb begin
    pin_next = 1'b1;
    unique case (state)
      START:   pin_next = 1'b0;
      DATA:    pin_next = shreg[idx];
      PARITY:  pin_next = par_q;
      default: pin_next = 1'b1;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      TX_Pin_Out  <= 1'b1;
      TX_Busy     <= 1'b0;
      TX_Done_Sig <= 1'b0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
      if (accept) begin
        shreg <= TX_Data;
      end
      if (TX_En_Sig) begin
        TX_Pin_Out <= pin_next;
      end
      // Busy drops together with the done pulse, when DONE hands over to IDLE.
      TX_Busy     <= (state_next != IDLE);
      TX_Done_Sig <= TX_En_Sig && (state == DONE);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl at CLK_FREQ=1 MHz, BAUD=100 kbit/s, so a
//   bit lasts 10 clocks. Traces of pin/busy/done are recorded once per cycle
//   (on the falling edge, index k = cycles after the accept edge) and each
//   test task compares them with hand-derived expected values.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  // Clock / reset
  logic       CLK = 1'b0;
  logic       RSTn;
  logic       TX_En_Sig;
  logic       TX_Start;
  logic [7:0] TX_Data;
  logic       TX_Busy;
  logic       TX_Done_Sig;
  logic       TX_Pin_Out;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .PARITY_ODD(1'b0)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .TX_En_Sig  (TX_En_Sig),
    .TX_Start   (TX_Start),
    .TX_Data    (TX_Data),
    .TX_Busy    (TX_Busy),
    .TX_Done_Sig(TX_Done_Sig),
    .TX_Pin_Out (TX_Pin_Out)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic pin_tr  [0:299];
  logic busy_tr [0:299];
  logic done_tr [0:299];

  // Scoreboard for the back-to-back receive check
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // Driver: request 'data', then record ncyc+1 cycles of outputs.
  // TX_Start stays high for edges 1..start_until-1, is pulsed on edge
  // poke_cyc with poke_data, and TX_En_Sig is low for frz_len edges from
  // frz_cyc. After the accept, TX_Data switches to data_after.
  task automatic drive_frame(input logic [7:0] data, input logic [7:0] data_after,
                             input int ncyc, input int start_until,
                             input int poke_cyc, input logic [7:0] poke_data,
                             input int frz_cyc, input int frz_len);
    @(negedge CLK);
    TX_Data   = data;
    TX_Start  = 1'b1;
    TX_En_Sig = 1'b1;
    @(posedge CLK);
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge CLK);
      pin_tr[k]  = TX_Pin_Out;
      busy_tr[k] = TX_Busy;
      done_tr[k] = TX_Done_Sig;
      if (k == 0) TX_Data = data_after;
      TX_Start = ((k + 1) < start_until) || ((k + 1) == poke_cyc);
      if ((k + 1) == poke_cyc) TX_Data = poke_data;
      TX_En_Sig = !(((k + 1) >= frz_cyc) && ((k + 1) < frz_cyc + frz_len));
    end
    TX_Start  = 1'b0;
    TX_En_Sig = 1'b1;
  endtask

  task automatic test_reset();
    RSTn      = 1'b0;
    TX_En_Sig = 1'b0;
    TX_Start  = 1'b0;
    TX_Data   = 8'h00;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (TX_Pin_Out !== 1'b1) begin
      n_err++; $display("FAIL reset_pin: got %b want 1", TX_Pin_Out);
    end
    n_cmp++;
    if (TX_Busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", TX_Busy);
    end
    n_cmp++;
    if (TX_Done_Sig !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b want 0", TX_Done_Sig);
    end
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_disabled_idle();
    int busy_seen;
    busy_seen = 0;
    TX_En_Sig = 1'b0;
    TX_Start  = 1'b1;
    TX_Data   = 8'hAA;
    repeat (20) begin
      @(negedge CLK);
      if (TX_Busy !== 1'b0 || TX_Pin_Out !== 1'b1) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0) begin
      n_err++; $display("FAIL disabled_idle_activity: got %0d active cycles want 0", busy_seen);
    end
    TX_Start  = 1'b0;
    TX_En_Sig = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (TX_Busy !== 1'b0) begin
      n_err++; $display("FAIL disabled_idle_no_queue: busy %b want 0", TX_Busy);
    end
  endtask

  task automatic test_a5_frame();
    logic [10:0] frm;
    logic        p;
    int          dcnt;
`ifdef UART_TX_PARITY_EN
    p = 1'b0;  // four ones -> even parity 0
`else
    p = 1'b1;
`endif
    // start, D0..D7 = 1,0,1,0,0,1,0,1, parity, stop
    frm = {1'b1, p, 8'hA5, 1'b0};
    drive_frame(8'hA5, 8'h5A, 130, 0, -1, 8'h00, 0, 0);
    n_cmp++;
    if (pin_tr[0] !== 1'b1) begin
      n_err++; $display("FAIL a5_pin_on_accept: got %b want 1", pin_tr[0]);
    end
    for (int b = 0; b < 11; b++) begin
      n_cmp++;
      if (pin_tr[5 + 10 * b] !== frm[b]) begin
        n_err++; $display("FAIL a5_bit%0d: got %b want %b", b, pin_tr[5 + 10 * b], frm[b]);
      end
    end
    n_cmp++;
    if (done_tr[111] !== 1'b1) begin
      n_err++; $display("FAIL a5_done_111: got %b want 1", done_tr[111]);
    end
    dcnt = 0;
    for (int k = 0; k <= 130; k++) if (done_tr[k] === 1'b1) dcnt++;
    n_cmp++;
    if (dcnt != 1) begin
      n_err++; $display("FAIL a5_done_count: got %0d want 1", dcnt);
    end
    n_cmp++;
    if (busy_tr[0] !== 1'b1) begin
      n_err++; $display("FAIL a5_busy_0: got %b want 1", busy_tr[0]);
    end
    n_cmp++;
    if (busy_tr[110] !== 1'b1) begin
      n_err++; $display("FAIL a5_busy_110: got %b want 1", busy_tr[110]);
    end
    n_cmp++;
    if (busy_tr[111] !== 1'b0) begin
      n_err++; $display("FAIL a5_busy_111: got %b want 0", busy_tr[111]);
    end
  endtask

  task automatic test_parity();
    logic p07, p03;
`ifdef UART_TX_PARITY_EN
    p07 = 1'b1;
    p03 = 1'b0;
`else
    p07 = 1'b1;
    p03 = 1'b1;
`endif
    drive_frame(8'h07, 8'h00, 115, 0, -1, 8'h00, 0, 0);
    n_cmp++;
    if (pin_tr[95] !== p07) begin
      n_err++; $display("FAIL parity_07: got %b want %b", pin_tr[95], p07);
    end
    drive_frame(8'h03, 8'hFF, 115, 0, -1, 8'h00, 0, 0);
    n_cmp++;
    if (pin_tr[95] !== p03) begin
      n_err++; $display("FAIL parity_03: got %b want %b", pin_tr[95], p03);
    end
  endtask

  task automatic test_busy_reject();
    logic [10:0] frm;
    logic        p;
    int          dcnt;
    int          bad;
`ifdef UART_TX_PARITY_EN
    p = 1'b0;
`else
    p = 1'b1;
`endif
    frm = {1'b1, p, 8'h55, 1'b0};
    drive_frame(8'h55, 8'h55, 250, 0, 40, 8'hFF, 0, 0);
    for (int b = 0; b < 11; b++) begin
      n_cmp++;
      if (pin_tr[5 + 10 * b] !== frm[b]) begin
        n_err++; $display("FAIL reject_bit%0d: got %b want %b", b, pin_tr[5 + 10 * b], frm[b]);
      end
    end
    dcnt = 0;
    for (int k = 0; k <= 250; k++) if (done_tr[k] === 1'b1) dcnt++;
    n_cmp++;
    if (dcnt != 1) begin
      n_err++; $display("FAIL reject_done_count: got %0d want 1", dcnt);
    end
    bad = 0;
    for (int k = 111; k <= 250; k++) if (pin_tr[k] !== 1'b1 || busy_tr[k] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL reject_no_second_frame: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_freeze();
    logic [10:0] frm;
    logic        p;
    logic        exp_pin;
    int          eff, bad, first_bad, dcnt;
`ifdef UART_TX_PARITY_EN
    p = 1'b0;
`else
    p = 1'b1;
`endif
    frm = {1'b1, p, 8'hC3, 1'b0};
    drive_frame(8'hC3, 8'h3C, 160, 0, -1, 8'h00, 33, 25);
    bad = 0;
    first_bad = -1;
    for (int k = 0; k <= 160; k++) begin
      // edges 33..57 are frozen: the line keeps the level seen after edge 32
      eff = (k < 33) ? k : ((k < 58) ? 32 : k - 25);
      exp_pin = (eff >= 1 && eff <= 110) ? frm[(eff - 1) / 10] : 1'b1;
      if (pin_tr[k] !== exp_pin) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL freeze_trace: got %0d wrong cycles (first at %0d) want 0", bad, first_bad);
    end
    n_cmp++;
    if (done_tr[136] !== 1'b1) begin
      n_err++; $display("FAIL freeze_done_136: got %b want 1", done_tr[136]);
    end
    dcnt = 0;
    for (int k = 0; k <= 160; k++) if (done_tr[k] === 1'b1) dcnt++;
    n_cmp++;
    if (dcnt != 1) begin
      n_err++; $display("FAIL freeze_done_count: got %0d want 1", dcnt);
    end
    n_cmp++;
    if (busy_tr[45] !== 1'b1) begin
      n_err++; $display("FAIL freeze_busy_held: got %b want 1", busy_tr[45]);
    end
  endtask

  task automatic test_back_to_back();
    int         k;
    logic [7:0] b;
    logic [7:0] e;
    int         dcnt;
    exp_q.delete();
    rx_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    drive_frame(8'h00, 8'h01, 240, 113, -1, 8'h00, 0, 0);
    // Simple receive path: find a falling edge, sample the bit centres.
    k = 1;
    while (k < 230) begin
      if (pin_tr[k] === 1'b0 && pin_tr[k - 1] === 1'b1) begin
        for (int i = 0; i < 8; i++) b[i] = pin_tr[k + 4 + 10 * (i + 1)];
        rx_q.push_back(b);
        k = k + 110;
      end else begin
        k++;
      end
    end
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_err++; $display("FAIL b2b_frame_count: got %0d want 2", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rx_q.size() == 0) begin
        n_err++; $display("FAIL b2b_byte: got none want %h", e);
      end else begin
        b = rx_q.pop_front();
        if (b !== e) begin
          n_err++; $display("FAIL b2b_byte: got %h want %h", b, e);
        end
      end
    end
    n_cmp++;
    if (pin_tr[112] !== 1'b1 || pin_tr[113] !== 1'b0) begin
      n_err++; $display("FAIL b2b_second_start: got %b%b want 10", pin_tr[112], pin_tr[113]);
    end
    dcnt = 0;
    for (int j = 0; j <= 240; j++) if (done_tr[j] === 1'b1) dcnt++;
    n_cmp++;
    if (done_tr[111] !== 1'b1 || done_tr[223] !== 1'b1 || dcnt != 2) begin
      n_err++; $display("FAIL b2b_done: got d111=%b d223=%b count=%0d want 1 1 2",
                        done_tr[111], done_tr[223], dcnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] frm;
    logic        p;
    int          dcnt;
    drive_frame(8'h00, 8'hFF, 45, 0, -1, 8'h00, 0, 0);
    n_cmp++;
    if (pin_tr[45] !== 1'b0) begin
      n_err++; $display("FAIL midreset_pin_before: got %b want 0", pin_tr[45]);
    end
    #1 RSTn = 1'b0;
    #1;
    n_cmp++;
    if (TX_Pin_Out !== 1'b1 || TX_Busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_async: got pin=%b busy=%b want 1 0", TX_Pin_Out, TX_Busy);
    end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
`ifdef UART_TX_PARITY_EN
    p = 1'b0;
`else
    p = 1'b1;
`endif
    frm = {1'b1, p, 8'h3C, 1'b0};
    drive_frame(8'h3C, 8'h00, 130, 0, -1, 8'h00, 0, 0);
    for (int b = 0; b < 11; b++) begin
      n_cmp++;
      if (pin_tr[5 + 10 * b] !== frm[b]) begin
        n_err++; $display("FAIL midreset_bit%0d: got %b want %b", b, pin_tr[5 + 10 * b], frm[b]);
      end
    end
    dcnt = 0;
    for (int k = 0; k <= 130; k++) if (done_tr[k] === 1'b1) dcnt++;
    n_cmp++;
    if (done_tr[111] !== 1'b1 || dcnt != 1) begin
      n_err++; $display("FAIL midreset_done: got d111=%b count=%0d want 1 1", done_tr[111], dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_disabled_idle();
    test_a5_frame();
    test_parity();
    test_busy_reject();
    test_freeze();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
